ata_pio_device: RTL and testbench
=================================

// Module: ata_pio_device
// PURPOSE
//  Device-side (responder) end of the ATA PIO interface driven by the OCIDEC host controllers.
//  Decodes the host strobes and provides a task-file register set plus a one-sector word buffer.
//  Drives read data, IORDY and INTRQ back to the host.
//  Used as a synthesizable on-chip target for host-controller loopback tests and emulation.
// PARAMETERS
//  DEPTH      256  words per sector buffer (power of 2)
//  AWIDTH     8    buffer address width, log2(DEPTH)
//  CMD_DLY    16   clk cycles BSY stays set after command accept and after final word of a write
//  IORDY_WAIT 0    clk cycles IORDY held low per data-register access; 0 = IORDY never driven low
//  CNTW       8    width of delay counters; must hold max(CMD_DLY, IORDY_WAIT)
// PORTS
//  clk    in  1  master clock
//  nReset in  1  synchronous active-low reset
//  RESETn in  1  ATA hardware reset from host, active low, asynchronous to clk
//  DA     in  3  ATA register address
//  CS0n   in  1  command-block chip select, active low
//  CS1n   in  1  control-block chip select, active low
//  DIORn  in  1  read strobe, active low
//  DIOWn  in  1  write strobe, active low
//  DDi    in  16 data from host
//  DDo    out 16 data to host
//  DDoe   out 1  DDo output enable
//  IORDY  out 1  ready; low inserts wait states
//  INTRQ  out 1  interrupt request, active high
// BEHAVIOUR
//  Reset and outputs:
//   - nReset=0 at clk edge: DDo=0, DDoe=0, IORDY=1, INTRQ=0, status=0x50 (DRDY|DSC), error=0, other regs=0, state=IDLE.
//   - All outputs are registered.
//  Input synchronisation and strobe timing:
//   - RESETn, CSxn, DA, DIORn, DIOWn pass through a 2-flop synchronizer; DDi is sampled after the same delay.
//   - Synchronized RESETn=0 acts as nReset but is qualified by synchronization.
//   - A read starts on sync DIORn falling edge. DDoe=1 and DDo are valid 1 clk later, i.e. 3 clk after the pin edge.
//   - DDoe stays 1 until sync DIORn rises. Read side effects take place on the rising edge.
//   - A write is latched from sync DDi on the sync DIOWn rising edge.
//   - An access requires exactly one CSxn low. Both low or both high: ignore the access, DDoe stays 0.
//  Register map:
//   - CS0 DA0: data (16b).
//   - CS0 DA1: error(r)/features(w). DA2 sector count, DA3-5 LBA low/mid/high, DA6 device: 8b each, read back on DDo[7:0], DDo[15:8]=0.
//   - CS0 DA7: status(r)/command(w). Status bits: BSY7 DRDY6 DSC4 DRQ3 ERR0.
//   - CS1 DA6: alt-status(r)/device-control(w). Device-control bits: nIEN bit1, SRST bit2.
//   - Other CS1 addresses read 0 and ignore writes.
//   - Status read clears INTRQ. Alt-status read does not.
//   - While BSY=1, writes to every register except device-control are ignored.
//  State machine IDLE -> BUSY -> {XFER_RD | XFER_WR} -> (POST) -> IDLE:
//   - IDLE, command write:
//     - 0x20 (read sector): BSY=1, ERR=0, go BUSY.
//     - 0x30 (write sector): BSY=1, ERR=0, go BUSY.
//     - Any other code: ERR=1, error=0x04 (ABRT), assert INTRQ if nIEN=0, stay IDLE.
//   - BUSY: count CMD_DLY cycles. Then BSY=0, DRQ=1, pointer=0.
//     - Read cmd: go XFER_RD and assert INTRQ (if nIEN=0).
//     - Write cmd: go XFER_WR with no INTRQ.
//   - XFER_RD: each data read returns buf[pointer], then pointer+1. After word DEPTH-1: DRQ=0, go IDLE.
//   - XFER_WR: each data write stores buf[pointer], then pointer+1. After word DEPTH-1: DRQ=0, BSY=1, go POST.
//   - POST: count CMD_DLY cycles, then BSY=0, INTRQ=1 (if nIEN=0), go IDLE.
//   - Data-register access with DRQ=0: read returns 0, write is ignored, pointer unchanged.
//   - Pointer wraps at DEPTH only via the end-of-sector transition. Buffer contents persist across commands (loopback).
//  IORDY:
//   - If IORDY_WAIT>0, a data-register access drives IORDY=0 from the strobe-edge detect for IORDY_WAIT clk.
//   - Register accesses never drive IORDY low.
//  Soft reset (SRST):
//   - Writing SRST=1: BSY=1, DRQ=0, INTRQ=0, abort any state, pointer=0.
//   - Writing SRST=0 while it was 1: status=0x50, error=0x01, go IDLE.
//   - Hardware reset and SRST never clear the buffer RAM.
//  Simultaneous events: SRST or reset overrides any state-machine update in the same cycle.
// TESTING
//  - After reset: read CS0 DA7 -> DDo=0x0050, INTRQ=0, IORDY=1, DDoe=0 between strobes.
//  - Write 0x30 to command, poll until BSY=0/DRQ=1, write DEPTH words 0x0000..DEPTH-1 -> after CMD_DLY clk, status=0x50 and INTRQ=1; status read clears INTRQ.
//  - Write 0x20, wait for INTRQ, read DEPTH data words -> values 0x0000..DEPTH-1 in order, DRQ=0 after the last; an extra read returns 0.
//  - Write command 0xEC -> status=0x51, error=0x04, INTRQ=1; with nIEN=1 the same command gives INTRQ=0.
//  - Mid-transfer (word 5 of a read) write SRST=1 then 0 -> BSY seen, then status=0x50, error=0x01, next 0x20 read starts at word 0.
//  - IORDY_WAIT=4: data read -> IORDY low exactly 4 clk; CS0n and CS1n both low -> DDoe stays 0, no register changes.

Source files
------------

// File: rtl/ata_pio_device.sv
// ata_pio_device: device-side ATA PIO responder with task-file registers and a one-sector loopback buffer
module ata_pio_device #(
  parameter int DEPTH      = 256,
  parameter int AWIDTH     = 8,
  parameter int CMD_DLY    = 16,
  parameter int IORDY_WAIT = 0,
  parameter int CNTW       = 8
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        RESETn,
  input  logic [2:0]  DA,
  input  logic        CS0n,
  input  logic        CS1n,
  input  logic        DIORn,
  input  logic        DIOWn,
  input  logic [15:0] DDi,
  output logic [15:0] DDo,
  output logic        DDoe,
  output logic        IORDY,
  output logic        INTRQ
);
  typedef enum logic [2:0] {IDLE, BUSY, XFER_RD, XFER_WR, POST} state_t;
  localparam logic [23:0] PIN_IDLE = {3'b111, 3'b000, 2'b11, 16'h0000};
  state_t state;
  logic [23:0] q1, q2;
  logic s_resetn, s_cs0, s_cs1, s_rd, s_wr, p_rd, p_wr;
  logic [2:0] s_da;
  logic [15:0] s_dd, rd_val;
  logic rst, sel, rd_fall, rd_rise, wr_fall, wr_rise, cs0_acc, data_acc, tf_wr, ctl_wr, buf_we, last;
  logic bsy, drq, err, nien, srst, is_wr, rd_act, rd_data, rd_stat;
  logic [7:0] status, error, seccnt, lba_lo, lba_mid, lba_hi, dev;
  logic [AWIDTH-1:0] ptr;
  logic [CNTW-1:0] cnt, io_cnt;
  logic [15:0] mem [DEPTH];
  assign {s_resetn, s_cs0, s_cs1, s_da, s_rd, s_wr, s_dd} = q2;
  always_ff @(posedge clk)
    if (!nReset) begin
      q1 <= PIN_IDLE;
      q2 <= PIN_IDLE;
      p_rd <= 1'b1;
      p_wr <= 1'b1;
    end else begin
      q1 <= {RESETn, CS0n, CS1n, DA, DIORn, DIOWn, DDi};
      q2 <= q1;
      p_rd <= s_rd;
      p_wr <= s_wr;
    end
  assign rst = !nReset || !s_resetn;
  assign sel = s_cs0 ^ s_cs1;
  assign rd_fall = sel && p_rd && !s_rd;
  assign rd_rise = !p_rd && s_rd;
  assign wr_fall = sel && p_wr && !s_wr;
  assign wr_rise = sel && !p_wr && s_wr;
  assign cs0_acc = sel && !s_cs0;
  assign data_acc = cs0_acc && s_da == 3'd0;
  assign tf_wr = wr_rise && cs0_acc && !bsy;
  assign ctl_wr = wr_rise && !s_cs1 && s_da == 3'd6;
  assign buf_we = !rst && tf_wr && s_da == 3'd0 && state == XFER_WR;
  assign last = ptr == AWIDTH'(DEPTH - 1);
  assign status = {bsy, 1'b1, 1'b0, 1'b1, drq, 2'b00, err};
  always_comb begin
    rd_val = '0;
    if (!s_cs0)
      case (s_da)
        3'd0: rd_val = state == XFER_RD ? mem[ptr] : '0;
        3'd1: rd_val = {8'h00, error};
        3'd2: rd_val = {8'h00, seccnt};
        3'd3: rd_val = {8'h00, lba_lo};
        3'd4: rd_val = {8'h00, lba_mid};
        3'd5: rd_val = {8'h00, lba_hi};
        3'd6: rd_val = {8'h00, dev};
        3'd7: rd_val = {8'h00, status};
      endcase
    else if (s_da == 3'd6) rd_val = {8'h00, status};
  end
  always_ff @(posedge clk)
    if (buf_we) mem[ptr] <= s_dd;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {bsy, drq, err, nien, srst, is_wr, rd_act, rd_data, rd_stat} <= '0;
      {error, seccnt, lba_lo, lba_mid, lba_hi, dev} <= '0;
      ptr <= '0;
      cnt <= '0;
      io_cnt <= '0;
      DDo <= '0;
      DDoe <= 1'b0;
      IORDY <= 1'b1;
      INTRQ <= 1'b0;
    end else begin
      if (rd_fall) begin
        DDo <= rd_val;
        DDoe <= 1'b1;
        rd_act <= 1'b1;
        rd_data <= data_acc && state == XFER_RD;
        rd_stat <= cs0_acc && s_da == 3'd7;
      end
      // side effects of a read land when the strobe is released
      if (rd_rise && rd_act) begin
        DDoe <= 1'b0;
        rd_act <= 1'b0;
        if (rd_stat) INTRQ <= 1'b0;
        if (rd_data && state == XFER_RD) begin
          ptr <= ptr + 1'b1;
          if (last) begin
            drq <= 1'b0;
            state <= IDLE;
          end
        end
      end
      if (IORDY_WAIT > 0 && data_acc && (rd_fall || wr_fall)) begin
        IORDY <= 1'b0;
        io_cnt <= CNTW'(IORDY_WAIT - 1);
      end else if (!IORDY) begin
        if (io_cnt == '0) IORDY <= 1'b1;
        else io_cnt <= io_cnt - 1'b1;
      end
      if (tf_wr)
        case (s_da)
          3'd0: if (state == XFER_WR) begin
            ptr <= ptr + 1'b1;
            if (last) begin
              drq <= 1'b0;
              bsy <= 1'b1;
              state <= POST;
              cnt <= CNTW'(CMD_DLY - 1);
            end
          end
          3'd2: seccnt <= s_dd[7:0];
          3'd3: lba_lo <= s_dd[7:0];
          3'd4: lba_mid <= s_dd[7:0];
          3'd5: lba_hi <= s_dd[7:0];
          3'd6: dev <= s_dd[7:0];
          3'd7: if (state == IDLE) begin
            if (s_dd[7:0] == 8'h20 || s_dd[7:0] == 8'h30) begin
              bsy <= 1'b1;
              err <= 1'b0;
              is_wr <= s_dd[4];
              state <= BUSY;
              cnt <= CNTW'(CMD_DLY - 1);
            end else begin
              err <= 1'b1;
              error <= 8'h04;
              if (!nien) INTRQ <= 1'b1;
            end
          end
          default: ;
        endcase
      if (state == BUSY || state == POST) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          bsy <= 1'b0;
          if (!nien && !(state == BUSY && is_wr)) INTRQ <= 1'b1;
          if (state == BUSY) begin
            drq <= 1'b1;
            ptr <= '0;
            state <= is_wr ? XFER_WR : XFER_RD;
          end else state <= IDLE;
        end
      end
      // device-control writes win over any state-machine update this cycle
      if (ctl_wr) begin
        nien <= s_dd[1];
        srst <= s_dd[2];
        if (s_dd[2]) begin
          bsy <= 1'b1;
          drq <= 1'b0;
          INTRQ <= 1'b0;
          state <= IDLE;
          ptr <= '0;
        end else if (srst) begin
          bsy <= 1'b0;
          drq <= 1'b0;
          err <= 1'b0;
          error <= 8'h01;
          state <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_ata_pio_device.sv
// tb_ata_pio_device: randomized pin-level host driving ata_pio_device, scoreboarded against a sector-level model
module tb_ata_pio_device;
  localparam int DEPTH = 256;
  localparam int AW = 8;
  localparam int CMD_DLY = 16;
  localparam int IOW = 4;
  logic clk = 1'b0, nReset = 1'b0, RESETn = 1'b1;
  logic CS0n = 1'b1, CS1n = 1'b1, DIORn = 1'b1, DIOWn = 1'b1;
  logic [2:0] DA = '0;
  logic [15:0] DDi = '0, DDo;
  logic DDoe, IORDY, INTRQ;
  always #5 clk = ~clk;
  ata_pio_device #(.DEPTH(DEPTH), .AWIDTH(AW), .CMD_DLY(CMD_DLY), .IORDY_WAIT(IOW), .CNTW(8)) dut (
    .clk(clk), .nReset(nReset), .RESETn(RESETn), .DA(DA), .CS0n(CS0n), .CS1n(CS1n),
    .DIORn(DIORn), .DIOWn(DIOWn), .DDi(DDi), .DDo(DDo), .DDoe(DDoe), .IORDY(IORDY), .INTRQ(INTRQ));

  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model: sector-level view of the device
  logic [15:0] mbuf [DEPTH];
  logic [7:0] tf [8];
  logic [7:0] m_err_r;
  bit m_bsy, m_drq, m_err, m_intrq, m_nien, m_srst;
  int m_phase;  // 0 idle, 1 read cmd pending, 2 write cmd pending, 3 reading, 4 writing, 5 write finishing
  int m_ptr, data_acc = 0;

  function automatic logic [15:0] m_status();
    return {8'h00, m_bsy, 1'b1, 1'b0, 1'b1, m_drq, 2'b00, m_err};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) tf[i] = '0;
    m_err_r = '0;
    {m_bsy, m_drq, m_err, m_intrq, m_nien, m_srst} = '0;
    m_phase = 0;
    m_ptr = 0;
  endtask

  task automatic m_settle();
    if (m_phase == 1 || m_phase == 2) begin
      m_bsy = 0;
      m_drq = 1;
      m_ptr = 0;
      if (m_phase == 1 && !m_nien) m_intrq = 1;
      m_phase = m_phase + 2;
    end else if (m_phase == 5) begin
      m_bsy = 0;
      m_phase = 0;
      if (!m_nien) m_intrq = 1;
    end
  endtask

  task automatic m_rd(input bit c0, input bit c1, input logic [2:0] da, output logic [15:0] v);
    v = '0;
    if (!c0 && c1)
      case (da)
        3'd0: begin
          data_acc++;
          if (m_phase == 3) begin
            v = mbuf[m_ptr];
            m_ptr++;
            if (m_ptr == DEPTH) begin m_ptr = 0; m_drq = 0; m_phase = 0; end
          end
        end
        3'd1: v = {8'h00, m_err_r};
        3'd7: begin v = m_status(); m_intrq = 0; end
        default: v = {8'h00, tf[da]};
      endcase
    else if (c0 && !c1 && da == 3'd6) v = m_status();
  endtask

  task automatic m_wr(input bit c0, input bit c1, input logic [2:0] da, input logic [15:0] v);
    if (!c0 && c1) begin
      if (da == 3'd0) data_acc++;
      if (!m_bsy)
        case (da)
          3'd0: if (m_phase == 4) begin
            mbuf[m_ptr] = v;
            m_ptr++;
            if (m_ptr == DEPTH) begin m_ptr = 0; m_drq = 0; m_bsy = 1; m_phase = 5; end
          end
          3'd1: ;
          3'd7: if (m_phase == 0) begin
            if (v[7:0] == 8'h20 || v[7:0] == 8'h30) begin
              m_bsy = 1; m_err = 0; m_phase = v[7:0] == 8'h20 ? 1 : 2;
            end else begin
              m_err = 1; m_err_r = 8'h04;
              if (!m_nien) m_intrq = 1;
            end
          end
          default: tf[da] = v[7:0];
        endcase
    end else if (c0 && !c1 && da == 3'd6) begin
      m_nien = v[1];
      if (v[2]) begin
        m_srst = 1; m_bsy = 1; m_drq = 0; m_intrq = 0; m_phase = 0; m_ptr = 0;
      end else if (m_srst) begin
        m_srst = 0; m_bsy = 0; m_drq = 0; m_err = 0; m_err_r = 8'h01; m_phase = 0;
      end
    end
  endtask

  logic [15:0] exp_q [$];
  string tag_q [$];

  task automatic host_rd(input bit c0, input bit c1, input logic [2:0] da, input string name);
    logic [15:0] v;
    m_rd(c0, c1, da, v);
    if (c0 ^ c1) begin exp_q.push_back(v); tag_q.push_back(name); end
    @(negedge clk); DA = da; CS0n = c0; CS1n = c1;
    repeat (2) @(negedge clk); DIORn = 1'b0;
    repeat (6) @(negedge clk); DIORn = 1'b1;
    repeat (4) @(negedge clk); CS0n = 1'b1; CS1n = 1'b1;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s: DDoe never asserted, %0d read(s) outstanding", name, exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic host_wr(input bit c0, input bit c1, input logic [2:0] da, input logic [15:0] v);
    m_wr(c0, c1, da, v);
    @(negedge clk); DA = da; CS0n = c0; CS1n = c1; DDi = v;
    repeat (2) @(negedge clk); DIOWn = 1'b0;
    repeat (6) @(negedge clk); DIOWn = 1'b1;
    repeat (4) @(negedge clk); CS0n = 1'b1; CS1n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    repeat (CMD_DLY + 24) @(negedge clk);
    m_settle();
  endtask

  task automatic read_sector(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      host_rd(1'b0, 1'b1, 3'd0, name);
      if ($urandom_range(0, 31) == 0) host_rd(1'b0, 1'b1, 3'($urandom_range(1, 6)), "tf_mid_rd");
    end
  endtask

  // monitor: pop one expectation per DDoe assertion; every IORDY low pulse must last IOW clocks
  int n_oe = 0, low_run = 0, pulses = 0;
  logic oe_q = 1'b0;
  logic [15:0] mon_exp;
  string mon_tag;
  always @(negedge clk) begin
    if (DDoe === 1'b1 && oe_q !== 1'b1) begin
      n_oe++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ddoe: DDoe asserted with DDo=%h, no read outstanding", DDo);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        chk(mon_tag, DDo, mon_exp);
      end
    end
    oe_q = DDoe;
    if (IORDY === 1'b0) low_run++;
    else if (low_run > 0) begin
      chk("iordy_width", 16'(low_run), 16'(IOW));
      pulses++;
      low_run = 0;
    end
  end

  initial begin
    logic [2:0] da;
    logic [7:0] code;
    int oe_snap;
    m_reset();
    repeat (5) @(negedge clk);
    nReset = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_ddo", DDo, 16'h0000);
    chk("reset_ddoe", {15'b0, DDoe}, 16'h0);
    chk("reset_iordy", {15'b0, IORDY}, 16'h1);
    chk("reset_intrq", {15'b0, INTRQ}, 16'h0);
    host_rd(1'b0, 1'b1, 3'd7, "status_after_reset");
    for (int i = 0; i < 8; i++) begin
      da = 3'($urandom_range(2, 6));
      host_wr(1'b0, 1'b1, da, 16'($urandom));
      host_rd(1'b0, 1'b1, da, "tf_readback");
    end
    host_rd(1'b0, 1'b1, 3'd1, "error_reset");
    host_rd(1'b1, 1'b0, 3'd3, "cs1_unmapped");
    host_rd(1'b1, 1'b0, 3'd6, "altstatus_idle");
    host_rd(1'b0, 1'b1, 3'd0, "data_no_drq");
    // write sector
    host_wr(1'b0, 1'b1, 3'd7, 16'h0030);
    host_rd(1'b0, 1'b1, 3'd7, "status_busy");
    settle();
    chk("intrq_wr_start", {15'b0, INTRQ}, {15'b0, m_intrq});
    host_rd(1'b0, 1'b1, 3'd7, "status_wr_drq");
    for (int i = 0; i < DEPTH; i++) begin
      host_wr(1'b0, 1'b1, 3'd0, 16'($urandom));
      if ($urandom_range(0, 15) == 0 || i == DEPTH - 1) host_rd(1'b1, 1'b0, 3'd6, "alt_during_wr");
    end
    settle();
    chk("intrq_wr_done", {15'b0, INTRQ}, {15'b0, m_intrq});
    host_rd(1'b1, 1'b0, 3'd6, "alt_keeps_intrq");
    chk("intrq_after_alt", {15'b0, INTRQ}, {15'b0, m_intrq});
    host_rd(1'b0, 1'b1, 3'd7, "status_wr_done");
    chk("intrq_cleared", {15'b0, INTRQ}, {15'b0, m_intrq});
    // read sector back
    host_wr(1'b0, 1'b1, 3'd7, 16'h0020);
    settle();
    chk("intrq_rd_ready", {15'b0, INTRQ}, {15'b0, m_intrq});
    host_rd(1'b0, 1'b1, 3'd7, "status_rd_drq");
    read_sector("data_rd");
    host_rd(1'b0, 1'b1, 3'd7, "status_rd_done");
    host_rd(1'b0, 1'b1, 3'd0, "data_extra");
    // rejected commands
    for (int k = 0; k < 3; k++) begin
      code = 8'hEC;
      if (k > 0) do code = 8'($urandom_range(0, 255)); while (code == 8'h20 || code == 8'h30);
      host_wr(1'b0, 1'b1, 3'd7, {8'h00, code});
      chk("intrq_abort", {15'b0, INTRQ}, {15'b0, m_intrq});
      host_rd(1'b0, 1'b1, 3'd7, "status_abort");
      host_rd(1'b0, 1'b1, 3'd1, "error_abort");
    end
    host_wr(1'b1, 1'b0, 3'd6, 16'h0002);
    host_wr(1'b0, 1'b1, 3'd7, 16'h00EC);
    chk("intrq_masked", {15'b0, INTRQ}, {15'b0, m_intrq});
    host_rd(1'b0, 1'b1, 3'd7, "status_masked");
    host_wr(1'b1, 1'b0, 3'd6, 16'h0000);
    // soft reset in the middle of a read
    host_wr(1'b0, 1'b1, 3'd7, 16'h0020);
    settle();
    host_rd(1'b0, 1'b1, 3'd7, "status_pre_srst");
    for (int i = 0; i < 5; i++) host_rd(1'b0, 1'b1, 3'd0, "data_pre_srst");
    host_wr(1'b1, 1'b0, 3'd6, 16'h0004);
    host_rd(1'b1, 1'b0, 3'd6, "alt_in_srst");
    chk("intrq_in_srst", {15'b0, INTRQ}, {15'b0, m_intrq});
    host_wr(1'b0, 1'b1, 3'd7, 16'h0030);
    host_wr(1'b0, 1'b1, 3'd3, 16'h005A);
    host_wr(1'b1, 1'b0, 3'd6, 16'h0000);
    host_rd(1'b0, 1'b1, 3'd7, "status_post_srst");
    host_rd(1'b0, 1'b1, 3'd1, "error_post_srst");
    host_rd(1'b0, 1'b1, 3'd3, "tf_kept_in_busy");
    host_wr(1'b0, 1'b1, 3'd7, 16'h0020);
    settle();
    host_rd(1'b0, 1'b1, 3'd7, "status_rd2");
    read_sector("data_rd_after_srst");
    // invalid chip-select combinations
    oe_snap = n_oe;
    host_wr(1'b0, 1'b0, 3'd3, 16'h00A5);
    host_rd(1'b0, 1'b0, 3'd3, "both_cs");
    host_rd(1'b0, 1'b0, 3'd0, "both_cs_data");
    host_rd(1'b1, 1'b1, 3'd7, "no_cs");
    chk("ddoe_silent", 16'(n_oe), 16'(oe_snap));
    host_rd(1'b0, 1'b1, 3'd3, "tf_after_both_cs");
    // hardware reset keeps the buffer
    host_wr(1'b0, 1'b1, 3'd4, 16'($urandom));
    @(negedge clk); RESETn = 1'b0;
    repeat (4) @(negedge clk); RESETn = 1'b1;
    repeat (6) @(negedge clk);
    m_reset();
    chk("hwreset_intrq", {15'b0, INTRQ}, 16'h0);
    host_rd(1'b0, 1'b1, 3'd7, "status_hwreset");
    host_rd(1'b0, 1'b1, 3'd1, "error_hwreset");
    host_rd(1'b0, 1'b1, 3'd4, "tf_hwreset");
    host_wr(1'b0, 1'b1, 3'd7, 16'h0020);
    settle();
    read_sector("data_after_hwreset");
    repeat (10) @(negedge clk);
    chk("iordy_pulses", 16'(pulses), 16'(data_acc));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
